// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style control unit.
// A single FSM walks each instruction through fetch, decode, execute,
// memory and write-back phases. The datapath strobes and mux selects are
// decoded from the current state, gated only by mem_ready and alu_bcond.
// instret counts retired instructions. HALT is left only through reset.
module multicycle_ctrl #(
    parameter bit ECALL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        alu_bcond,
    input  logic        x17_is_ten,
    output logic        pc_write,
    output logic        pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op_sel,
    output logic        is_halted,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [3:0] S_IF      = 4'd0;
    localparam logic [3:0] S_ID      = 4'd1;
    localparam logic [3:0] S_EX_R    = 4'd2;
    localparam logic [3:0] S_EX_I    = 4'd3;
    localparam logic [3:0] S_EX_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD  = 4'd5;
    localparam logic [3:0] S_MEM_WR  = 4'd6;
    localparam logic [3:0] S_WB_ALU  = 4'd7;
    localparam logic [3:0] S_WB_MEM  = 4'd8;
    localparam logic [3:0] S_EX_BR   = 4'd9;
    localparam logic [3:0] S_EX_JAL  = 4'd10;
    localparam logic [3:0] S_EX_JALR = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [3:0]  state_q;
    logic [3:0]  next_state;
    logic [31:0] instret_q;
    logic        retire;

    assign state   = state_q;
    assign instret = instret_q;

    // An instruction retires when any working state hands back to IF or
    // enters HALT; the HALT self-loop and IF wait cycles do not count.
    assign retire = (state_q != S_IF) && (state_q != S_HALT) &&
                    ((next_state == S_IF) || (next_state == S_HALT));

    // State register: reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IF;
        else       state_q <= next_state;
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       instret_q <= 32'd0;
        else if (retire) instret_q <= instret_q + 32'd1;
    end

    // Next-state logic. The IR stays stable after fetch, so opcode is still
    // valid in EX_ADDR to choose between load (bit 5 clear) and store.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IF:      if (mem_ready) next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_R:               next_state = S_EX_R;
                    OP_I:               next_state = S_EX_I;
                    OP_LOAD, OP_STORE:  next_state = S_EX_ADDR;
                    OP_BRANCH:          next_state = S_EX_BR;
                    OP_JAL:             next_state = S_EX_JAL;
                    OP_JALR:            next_state = S_EX_JALR;
                    OP_SYSTEM:          next_state = (ECALL_HALT && x17_is_ten) ? S_HALT : S_IF;
                    default:            next_state = S_IF;
                endcase
            end
            S_EX_R, S_EX_I: next_state = S_WB_ALU;
            S_EX_ADDR: next_state = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) next_state = S_WB_MEM;
            S_MEM_WR:  if (mem_ready) next_state = S_IF;
            S_WB_ALU, S_WB_MEM, S_EX_BR, S_EX_JAL, S_EX_JALR: next_state = S_IF;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_IF;
        endcase
    end

    // Control decode. Everything is held at zero while reset is high so no
    // strobe (not even the fetch read) leaks out during reset.
    always_comb begin
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op_sel = 2'b00;
        is_halted  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                S_EX_R: begin
                    alu_src_a  = 2'b01;
                    alu_op_sel = 2'b01;
                end
                S_EX_I: begin
                    alu_src_a  = 2'b01;
                    alu_src_b  = 2'b10;
                    alu_op_sel = 2'b01;
                end
                S_EX_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_WB_ALU: reg_write = 1'b1;
                S_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b01;
                end
                S_EX_BR: begin
                    alu_src_a  = 2'b01;
                    alu_op_sel = 2'b10;
                    pc_source  = 1'b1;
                    pc_write   = alu_bcond;
                end
                S_EX_JAL: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                end
                S_EX_JALR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    reg_write = 1'b1;
                    wb_sel    = 2'b10;
                    pc_write  = 1'b1;
                end
                S_HALT:  is_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each instruction's expected per-cycle
// control vector is queued when the instruction is set up and compared
// cycle by cycle. Inputs are driven on the falling edge and outputs sampled
// 1 time unit later, so every sample sits between rising edges.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        alu_bcond;
    logic        x17_is_ten;
    logic        pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op_sel;
    logic        is_halted;
    logic [3:0]  state;
    logic [31:0] instret;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret;
    logic [19:0] exp_q[$];

    multicycle_ctrl #(.ECALL_HALT(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .alu_bcond(alu_bcond), .x17_is_ten(x17_is_ten),
        .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel), .is_halted(is_halted),
        .state(state), .instret(instret)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Packed control vector: {state, pc_write, pc_source, ir_write, i_or_d,
    // mem_read, mem_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op_sel, is_halted}
    function automatic logic [19:0] mk(input logic [3:0] st, input logic pcw, input logic pcs,
                                       input logic irw, input logic iod, input logic mr,
                                       input logic mw, input logic rw, input logic [1:0] wb,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic h);
        return {st, pcw, pcs, irw, iod, mr, mw, rw, wb, sa, sb, op, h};
    endfunction

    localparam logic [19:0] C_RST     = mk(4'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_IF_RDY  = mk(4'd0,  1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd1,2'd0, 1'b0);
    localparam logic [19:0] C_IF_WAIT = mk(4'd0,  1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd1,2'd0, 1'b0);
    localparam logic [19:0] C_ID      = mk(4'd1,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd2,2'd2,2'd0, 1'b0);
    localparam logic [19:0] C_EX_R    = mk(4'd2,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd0,2'd1, 1'b0);
    localparam logic [19:0] C_EX_I    = mk(4'd3,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd1, 1'b0);
    localparam logic [19:0] C_EX_ADDR = mk(4'd4,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd2,2'd0, 1'b0);
    localparam logic [19:0] C_MEM_RD  = mk(4'd5,  1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_MEM_WR  = mk(4'd6,  1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_WB_ALU  = mk(4'd7,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_WB_MEM  = mk(4'd8,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd1,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_BR_NT   = mk(4'd9,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd0,2'd2, 1'b0);
    localparam logic [19:0] C_BR_T    = mk(4'd9,  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,2'd0,2'd2, 1'b0);
    localparam logic [19:0] C_JAL     = mk(4'd10, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2,2'd0,2'd0,2'd0, 1'b0);
    localparam logic [19:0] C_JALR    = mk(4'd11, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd2,2'd1,2'd2,2'd0, 1'b0);
    localparam logic [19:0] C_HALT    = mk(4'd12, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0,2'd0, 1'b1);

    function automatic logic [19:0] observe();
        return {state, pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write, reg_write,
                wb_sel, alu_src_a, alu_src_b, alu_op_sel, is_halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected vector and compare it with the outputs right now.
    task automatic check_now(input string tag);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {12'd0, observe()}, {12'd0, e});
        end
    endtask

    task automatic run_now(input string tag, input logic mr, input logic bc);
        mem_ready = mr;
        alu_bcond = bc;
        #1;
        check_now(tag);
    endtask

    task automatic run_cycle(input string tag, input logic mr, input logic bc);
        @(negedge clk);
        run_now(tag, mr, bc);
    endtask

    // After the closing edge of an instruction: state and instret.
    task automatic check_after(input string tag, input logic [3:0] exp_state);
        @(posedge clk);
        #1;
        check({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
        check({tag, "_instret"}, instret, exp_instret);
    endtask

    // Asynchronous reset asserted halfway through a cycle.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        exp_q.push_back(C_RST);
        check_now({tag, "_ctrl"});
        exp_instret = 32'd0;
        check({tag, "_instret"}, instret, exp_instret);
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        opcode      = 7'd0;
        mem_ready   = 1'b1;
        alu_bcond   = 1'b0;
        x17_is_ten  = 1'b0;
        exp_instret = 32'd0;

        // Reset state, with mem_ready high to show nothing leaks out.
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(C_RST);
        check_now("reset_ctrl");
        check("reset_instret", instret, 32'd0);

        // R-type, fetch starting on the first edge after reset release.
        opcode = 7'b0110011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        exp_q.push_back(C_EX_R);   exp_q.push_back(C_WB_ALU);
        @(negedge clk);
        reset = 1'b0;
        run_now("r_if", 1'b1, 1'b0);
        run_cycle("r_id", 1'b1, 1'b0);
        run_cycle("r_ex", 1'b1, 1'b0);
        run_cycle("r_wb", 1'b1, 1'b0);
        exp_instret++;
        check_after("r_end", 4'd0);

        // I-type.
        opcode = 7'b0010011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        exp_q.push_back(C_EX_I);   exp_q.push_back(C_WB_ALU);
        for (int i = 0; i < 4; i++) run_cycle("i_cyc", 1'b1, 1'b0);
        exp_instret++;
        check_after("i_end", 4'd0);

        // Load with three wait cycles; stray mem_ready in EX_ADDR and WB_MEM.
        opcode = 7'b0000011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_EX_ADDR);
        for (int i = 0; i < 4; i++) exp_q.push_back(C_MEM_RD);
        exp_q.push_back(C_WB_MEM);
        run_cycle("ld_if", 1'b1, 1'b0);
        run_cycle("ld_id", 1'b0, 1'b0);
        run_cycle("ld_addr", 1'b1, 1'b0);
        run_cycle("ld_wait0", 1'b0, 1'b0);
        run_cycle("ld_wait1", 1'b0, 1'b0);
        run_cycle("ld_wait2", 1'b0, 1'b0);
        run_cycle("ld_rdy", 1'b1, 1'b0);
        run_cycle("ld_wb", 1'b1, 1'b0);
        exp_instret++;
        check_after("ld_end", 4'd0);

        // Store, no waits.
        opcode = 7'b0100011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        exp_q.push_back(C_EX_ADDR); exp_q.push_back(C_MEM_WR);
        for (int i = 0; i < 4; i++) run_cycle("st_cyc", 1'b1, 1'b0);
        exp_instret++;
        check_after("st_end", 4'd0);

        // Unknown opcode retires as a two-cycle NOP.
        opcode = 7'b0000000;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        for (int i = 0; i < 2; i++) run_cycle("nop_cyc", 1'b1, 1'b0);
        exp_instret++;
        check_after("nop_end", 4'd0);

        // Branch not taken, then taken.
        opcode = 7'b1100011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_BR_NT);
        for (int i = 0; i < 3; i++) run_cycle("br_nt", 1'b1, 1'b0);
        exp_instret++;
        check_after("br_nt_end", 4'd0);
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_BR_T);
        for (int i = 0; i < 3; i++) run_cycle("br_t", 1'b1, 1'b1);
        exp_instret++;
        check_after("br_t_end", 4'd0);

        // JAL and JALR.
        opcode = 7'b1101111;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_JAL);
        for (int i = 0; i < 3; i++) run_cycle("jal", 1'b1, 1'b0);
        exp_instret++;
        check_after("jal_end", 4'd0);
        opcode = 7'b1100111;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_JALR);
        for (int i = 0; i < 3; i++) run_cycle("jalr", 1'b1, 1'b0);
        exp_instret++;
        check_after("jalr_end", 4'd0);

        // ECALL with x17 != 10 is a NOP.
        opcode     = 7'b1110011;
        x17_is_ten = 1'b0;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        for (int i = 0; i < 2; i++) run_cycle("ecall_nop", 1'b1, 1'b0);
        exp_instret++;
        check_after("ecall_nop_end", 4'd0);

        // ECALL with x17 == 10 halts and stays halted under random inputs.
        x17_is_ten = 1'b1;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID);
        for (int i = 0; i < 20; i++) exp_q.push_back(C_HALT);
        run_cycle("halt_if", 1'b1, 1'b0);
        run_cycle("halt_id", 1'b1, 1'b0);
        exp_instret++;
        for (int i = 0; i < 20; i++)
            run_cycle("halt_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_after("halt_end", 4'd12);
        x17_is_ten = 1'b0;

        // Only reset leaves HALT.
        async_reset("halt_rst");

        // Reset in the middle of a store's memory wait.
        opcode = 7'b0100011;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_EX_ADDR);
        exp_q.push_back(C_MEM_WR); exp_q.push_back(C_MEM_WR);
        run_cycle("stw_if", 1'b1, 1'b0);
        run_cycle("stw_id", 1'b1, 1'b0);
        run_cycle("stw_addr", 1'b1, 1'b0);
        run_cycle("stw_wait0", 1'b0, 1'b0);
        run_cycle("stw_wait1", 1'b0, 1'b0);
        async_reset("stw_rst");

        // instret wrap: preload all ones during an IF wait, then retire a JAL.
        exp_q.push_back(C_IF_WAIT);
        run_cycle("wrap_ifwait", 1'b0, 1'b0);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        opcode = 7'b1101111;
        exp_q.push_back(C_IF_RDY); exp_q.push_back(C_ID); exp_q.push_back(C_JAL);
        for (int i = 0; i < 3; i++) run_cycle("wrap_jal", 1'b1, 1'b0);
        exp_instret++;
        check_after("wrap_end", 4'd0);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
